// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the program counter, issues single-outstanding
// word fetches to instruction memory, buffers returned words with their PCs
// and hands them to the decoder. Redirects flush buffered and in-flight work.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  // S_DRAIN: a request is outstanding but its data belongs to a squashed path.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic [31:0]     r_fetch_pc;
  logic [31:0]     r_inflight_pc;

  logic [31:0]     r_buf_instr [DEPTH];
  logic [31:0]     r_buf_pc    [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic            r_instr_valid;
  logic [31:0]     r_instruction;
  logic [31:0]     r_pc_out;

  logic            w_req_valid;
  logic            w_req_fire;
  logic            w_push;
  logic            w_pop;
  logic [CW-1:0]   w_count_next;
  logic [PW-1:0]   w_rd_ptr_next;
  logic [PW-1:0]   w_wr_ptr_next;
  logic            w_head_valid;
  logic [31:0]     w_head_instr;
  logic [31:0]     w_head_pc;

  // Request only when nothing is outstanding and a buffer slot is guaranteed,
  // so a response can never land in a full buffer. A redirect suppresses the
  // request so the old path never issues in the redirect cycle.
  assign w_req_valid = !rst && (r_state == S_IDLE) && (r_count < CW'(DEPTH)) && !redirect_valid;
  assign w_req_fire  = w_req_valid && imem_req_ready;

  // A response in the redirect cycle is stale and dropped; a pop in the
  // redirect cycle is ignored because the whole buffer is discarded.
  assign w_push = (r_state == S_WAIT) && imem_rsp_valid && !redirect_valid;
  assign w_pop  = r_instr_valid && instr_ready && !redirect_valid;

  assign imem_req_valid = w_req_valid;
  assign imem_addr      = r_fetch_pc;
  assign instr_valid    = r_instr_valid;
  assign instruction    = r_instruction;
  assign pc_out         = r_pc_out;

  // Next fetch-FSM state: track whether the outstanding response is wanted.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req_fire) begin
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          w_state_next = S_IDLE;
        end else if (redirect_valid) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (imem_rsp_valid) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Next buffer occupancy and pointers; redirect empties the buffer.
  always_comb begin
    w_count_next  = r_count;
    w_rd_ptr_next = r_rd_ptr;
    w_wr_ptr_next = r_wr_ptr;
    if (redirect_valid) begin
      w_count_next  = '0;
      w_rd_ptr_next = '0;
      w_wr_ptr_next = '0;
    end else begin
      if (w_push && !w_pop) begin
        w_count_next = r_count + CW'(1);
      end else if (!w_push && w_pop) begin
        w_count_next = r_count - CW'(1);
      end
      if (w_pop) begin
        w_rd_ptr_next = r_rd_ptr + PW'(1);
      end
      if (w_push) begin
        w_wr_ptr_next = r_wr_ptr + PW'(1);
      end
    end
  end

  // Next head presented to the decoder. When the entry being pushed becomes
  // the only entry, it bypasses the array so the head is current next cycle.
  always_comb begin
    w_head_valid = 1'b0;
    w_head_instr = NOP_INSTR;
    w_head_pc    = '0;
    if (w_count_next != '0) begin
      w_head_valid = 1'b1;
      if (w_push && (w_count_next == CW'(1))) begin
        w_head_instr = imem_rsp_data;
        w_head_pc    = r_inflight_pc;
      end else begin
        w_head_instr = r_buf_instr[w_rd_ptr_next];
        w_head_pc    = r_buf_pc[w_rd_ptr_next];
      end
    end
  end

  // Control state: FSM, program counter, buffer bookkeeping, registered head.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_fetch_pc    <= RESET_PC;
      r_inflight_pc <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_instr_valid <= 1'b0;
      r_instruction <= NOP_INSTR;
      r_pc_out      <= '0;
    end else begin
      r_state       <= w_state_next;
      r_wr_ptr      <= w_wr_ptr_next;
      r_rd_ptr      <= w_rd_ptr_next;
      r_count       <= w_count_next;
      r_instr_valid <= w_head_valid;
      r_instruction <= w_head_instr;
      r_pc_out      <= w_head_pc;
      if (redirect_valid) begin
        r_fetch_pc <= {redirect_pc[31:2], 2'b00};
      end else if (w_req_fire) begin
        r_fetch_pc    <= r_fetch_pc + 32'd4;
        r_inflight_pc <= r_fetch_pc;
      end
    end
  end

  // Buffer storage: data only, no reset needed since occupancy guards reads.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_instr[r_wr_ptr] <= imem_rsp_data;
      r_buf_pc[r_wr_ptr]    <= r_inflight_pc;
    end
  end

endmodule
